// File: rtl/branch_resolve_queue_if.sv
// Prediction/resolve/training bundle between the predictor, execute stage and
// the in-flight branch queue.
interface branch_resolve_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic             pred_valid;
  logic             pred_taken;
  logic [TAG_W-1:0] pred_tag;
  logic             pred_ready;
  logic             res_valid;
  logic             res_taken;
  logic [TAG_W-1:0] res_tag;
  logic             upd_result;
  logic             upd_taken;
  logic             mispredict;
  logic [TAG_W-1:0] mispredict_tag;
  logic             tag_error;
  logic [OCC_W-1:0] count;
  logic [CNT_W-1:0] miss_count;

  modport master (
    output pred_valid, pred_taken, pred_tag, res_valid, res_taken, res_tag,
    input  pred_ready, upd_result, upd_taken, mispredict, mispredict_tag,
           tag_error, count, miss_count
  );

  modport slave (
    input  pred_valid, pred_taken, pred_tag, res_valid, res_taken, res_tag,
    output pred_ready, upd_result, upd_taken, mispredict, mispredict_tag,
           tag_error, count, miss_count
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of outstanding branch predictions; resolves the oldest entry,
// trains the predictor, flags mispredicts and flushes wrong-path entries.
module branch_resolve_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_resolve_queue_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef struct packed {
    logic             taken;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [OCC_W-1:0] count_q, count_next;
  logic [CNT_W-1:0] miss_q;
  logic             upd_result_q, upd_taken_q, mispredict_q, tag_error_q;
  logic [TAG_W-1:0] mispredict_tag_q;

  entry_t head;
  logic   empty, ready, push, pop, tag_ok, hit, flush, terr;

  // Head examination and queue control, all from registered occupancy
  always_comb begin
    head       = mem[rd_ptr];
    empty      = (count_q == '0);
    ready      = (count_q != OCC_W'(DEPTH));
    push       = bus.pred_valid && ready;
    pop        = bus.res_valid && !empty;
    tag_ok     = (head.tag == bus.res_tag);
    hit        = pop && tag_ok;
    flush      = hit && (head.taken != bus.res_taken);
    terr       = bus.res_valid && (empty || !tag_ok);
    count_next = count_q + OCC_W'(push) - OCC_W'(pop);
    if (flush) count_next = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count_q          <= '0;
      miss_q           <= '0;
      upd_result_q     <= 1'b0;
      upd_taken_q      <= 1'b0;
      mispredict_q     <= 1'b0;
      mispredict_tag_q <= '0;
      tag_error_q      <= 1'b0;
    end else begin
      count_q      <= count_next;
      upd_result_q <= hit;
      mispredict_q <= flush;
      tag_error_q  <= terr;
      if (hit) upd_taken_q <= bus.res_taken;
      // Flush drops the same-cycle push, so the write pointer stays put
      if (flush) begin
        rd_ptr           <= wr_ptr;
        mispredict_tag_q <= bus.res_tag;
        if (miss_q != '1) miss_q <= miss_q + CNT_W'(1);
      end else begin
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset; occupancy decides what is live
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= {bus.pred_taken, bus.pred_tag};
  end

  assign bus.pred_ready     = ready;
  assign bus.upd_result     = upd_result_q;
  assign bus.upd_taken      = upd_taken_q;
  assign bus.mispredict     = mispredict_q;
  assign bus.mispredict_tag = mispredict_tag_q;
  assign bus.tag_error      = tag_error_q;
  assign bus.count          = count_q;
  assign bus.miss_count     = miss_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized and directed bench for branch_resolve_queue against a queue-based
// reference model of the in-flight predictions.
module tb_branch_resolve_queue;
  localparam int DEPTH    = 4;
  localparam int TAG_W    = 8;
  localparam int CNT_W    = 4;
  localparam int MISS_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic       taken;
    logic [7:0] tag;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

  branch_resolve_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Observed outputs packed for whole-state comparison
  logic [19:0] obs;
  assign obs = {bus.upd_result, bus.upd_taken, bus.mispredict, bus.mispredict_tag,
                bus.tag_error, bus.count, bus.miss_count, bus.pred_ready};

  ent_t       q[$];
  int         m_miss = 0;
  logic       m_upd = 1'b0, m_ut = 1'b0, m_mp = 1'b0, m_te = 1'b0;
  logic [7:0] m_mtag = 8'h00;
  int         passed = 0;
  int         total = 0;

  function automatic logic [19:0] expv();
    logic [2:0] occ;
    logic [3:0] mc;
    occ = 3'(q.size());
    mc  = 4'(m_miss);
    return {m_upd, m_ut, m_mp, m_mtag, m_te, occ, mc, (q.size() < DEPTH)};
  endfunction

  function automatic void model_reset();
    q.delete();
    m_miss = 0; m_upd = 0; m_ut = 0; m_mp = 0; m_te = 0; m_mtag = 8'h00;
  endfunction

  // Drive one cycle, advance the model by the same transaction, settle past the edge
  task automatic step(input logic pv, input logic pt, input logic [7:0] ptag,
                      input logic rv, input logic rt, input logic [7:0] rtag);
    bit   push, pop, flush;
    ent_t h, n;
    bus.pred_valid = pv; bus.pred_taken = pt; bus.pred_tag = ptag;
    bus.res_valid  = rv; bus.res_taken  = rt; bus.res_tag  = rtag;
    push = pv && (q.size() < DEPTH);
    pop = 0; flush = 0; m_upd = 0; m_mp = 0; m_te = 0;
    if (rv) begin
      if (q.size() == 0) m_te = 1;
      else begin
        h = q[0];
        pop = 1;
        if (h.tag != rtag) m_te = 1;
        else begin
          m_upd = 1; m_ut = rt;
          if (h.taken != rt) begin
            m_mp = 1; m_mtag = rtag; flush = 1;
            if (m_miss < MISS_MAX) m_miss++;
          end
        end
      end
    end
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) begin n.taken = pt; n.tag = ptag; q.push_back(n); end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 0, 0, 8'h00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1, 1, 8'h55, 1, 1, 8'h55);
    model_reset();
    rst_n = 1'b1;
    total++;
    if (obs !== 20'h00001) $display("FAIL reset_state got %h expected %h", obs, 20'h00001);
    else passed++;
  endtask

  task automatic test_fill();
    logic [3:0] tk;
    tk = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      step(1, tk[i], 8'(8'h10 + i), 0, 0, 8'h00);
      total++;
      if (obs !== expv()) $display("FAIL fill_%0d got %h expected %h", i, obs, expv());
      else passed++;
    end
    total++;
    if (bus.pred_ready !== 1'b0 || bus.count !== 3'd4)
      $display("FAIL full_ready got ready=%b count=%0d expected ready=0 count=4", bus.pred_ready, bus.count);
    else passed++;
    step(1, 0, 8'h14, 0, 0, 8'h00);
    total++;
    if (bus.count !== 3'd4) $display("FAIL full_reject got count=%0d expected 4", bus.count);
    else passed++;
  endtask

  task automatic test_correct();
    step(0, 0, 8'h00, 1, 1, 8'h10);
    total++;
    if (bus.upd_result !== 1'b1 || bus.upd_taken !== 1'b1 || bus.mispredict !== 1'b0 || bus.count !== 3'd3)
      $display("FAIL correct_resolve got upd=%b tk=%b mp=%b count=%0d expected 1 1 0 3",
               bus.upd_result, bus.upd_taken, bus.mispredict, bus.count);
    else passed++;
  endtask

  task automatic test_flush();
    step(1, 1, 8'h30, 1, 1, 8'h11);
    total++;
    if (bus.mispredict !== 1'b1 || bus.mispredict_tag !== 8'h11 || bus.upd_result !== 1'b1 ||
        bus.upd_taken !== 1'b1 || bus.count !== 3'd0 || bus.miss_count !== 4'd1)
      $display("FAIL flush got mp=%b mtag=%h upd=%b tk=%b count=%0d miss=%0d expected 1 11 1 1 0 1",
               bus.mispredict, bus.mispredict_tag, bus.upd_result, bus.upd_taken, bus.count, bus.miss_count);
    else passed++;
    idle();
    total++;
    if (obs !== expv()) $display("FAIL flush_pulse_end got %h expected %h", obs, expv());
    else passed++;
  endtask

  task automatic test_tag_error();
    step(0, 0, 8'h00, 1, 0, 8'h20);
    total++;
    if (bus.tag_error !== 1'b1 || bus.upd_result !== 1'b0 || bus.count !== 3'd0)
      $display("FAIL empty_resolve got te=%b upd=%b count=%0d expected 1 0 0", bus.tag_error, bus.upd_result, bus.count);
    else passed++;
    step(1, 1, 8'h20, 0, 0, 8'h00);
    step(0, 0, 8'h00, 1, 1, 8'h21);
    total++;
    if (bus.tag_error !== 1'b1 || bus.upd_result !== 1'b0 || bus.mispredict !== 1'b0 || bus.count !== 3'd0)
      $display("FAIL tag_mismatch got te=%b upd=%b mp=%b count=%0d expected 1 0 0 0",
               bus.tag_error, bus.upd_result, bus.mispredict, bus.count);
    else passed++;
    // Push into empty queue while resolving: push lands, resolve is an empty error
    step(1, 0, 8'h22, 1, 0, 8'h22);
    total++;
    if (obs !== expv()) $display("FAIL push_empty_resolve got %h expected %h", obs, expv());
    else passed++;
    step(0, 0, 8'h00, 1, 0, 8'h22);
  endtask

  task automatic test_back_to_back();
    step(1, 1, 8'h40, 0, 0, 8'h00);
    step(1, 0, 8'h41, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      logic       ht;
      logic [7:0] hg;
      ht = q[0].taken; hg = q[0].tag;
      step(1, 1'($urandom_range(0, 1)), 8'(8'h42 + i), 1, ht, hg);
      total++;
      if (obs !== expv() || bus.count !== 3'd2 || bus.upd_result !== 1'b1)
        $display("FAIL b2b_%0d got %h expected %h", i, obs, expv());
      else passed++;
    end
    step(0, 0, 8'h00, 1, ~q[0].taken, q[0].tag);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic       pv, pt, rv, rt;
      logic [7:0] pg, rg;
      pv = 1'($urandom_range(0, 3) != 0);
      pt = 1'($urandom_range(0, 1));
      pg = 8'($urandom);
      rv = 1'($urandom_range(0, 2) == 0);
      rt = 1'($urandom_range(0, 1));
      rg = 8'($urandom);
      if (q.size() > 0 && $urandom_range(0, 7) != 0) rg = q[0].tag;
      if (q.size() > 0 && $urandom_range(0, 3) != 0) rt = q[0].taken;
      step(pv, pt, pg, rv, rt, rg);
      total++;
      if (obs !== expv()) $display("FAIL random_%0d got %h expected %h", i, obs, expv());
      else passed++;
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      step(1, 0, 8'(i), 0, 0, 8'h00);
      step(0, 0, 8'h00, 1, 1, 8'(i));
      total++;
      if (obs !== expv()) $display("FAIL sat_%0d got %h expected %h", i, obs, expv());
      else passed++;
    end
    total++;
    if (bus.miss_count !== 4'hF) $display("FAIL miss_saturate got %h expected f", bus.miss_count);
    else passed++;
    step(1, 1, 8'h70, 0, 0, 8'h00);
    step(1, 0, 8'h71, 1, 1, 8'h70);
    rst_n = 1'b0;
    step(1, 1, 8'h72, 1, 0, 8'h71);
    model_reset();
    rst_n = 1'b1;
    total++;
    if (obs !== 20'h00001 || bus.count !== 3'd0 || bus.miss_count !== 4'd0)
      $display("FAIL midstream_reset got %h expected %h", obs, 20'h00001);
    else passed++;
    idle();
    total++;
    if (obs !== expv()) $display("FAIL post_reset_idle got %h expected %h", obs, expv());
    else passed++;
  endtask

  initial begin
    bus.pred_valid = 0; bus.pred_taken = 0; bus.pred_tag = '0;
    bus.res_valid  = 0; bus.res_taken  = 0; bus.res_tag  = '0;
    test_reset();
    test_fill();
    test_correct();
    test_flush();
    test_tag_error();
    test_back_to_back();
    test_random();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
Tracks branch predictions that are still in flight, from the point the 2-bit saturating predictor issues them until the execute stage resolves them. Each prediction is enqueued in order. At resolution the oldest entry is compared with the actual outcome. The block then drives the predictor's training inputs (result/taken), flags mispredictions and flushes younger speculative entries.

Parameters:
DEPTH, 4, number of outstanding predictions; power of two, >=2
TAG_W, 8, width of branch tag (low PC bits) carried with each entry
CNT_W, 16, width of saturating mispredict statistics counter

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  synchronous reset, active-low
pred_valid  in  1  new prediction issued this cycle
pred_taken  in  1  predicted direction (predictor's prediction output)
pred_tag  in  TAG_W  tag of predicted branch
pred_ready  out  1  queue can accept a prediction
res_valid  in  1  execute stage resolves oldest branch this cycle
res_taken  in  1  actual branch outcome
res_tag  in  TAG_W  tag of resolved branch
upd_result  out  1  one-cycle pulse; drives predictor result
upd_taken  out  1  actual outcome; drives predictor taken, valid with upd_result
mispredict  out  1  one-cycle pulse: resolved direction != predicted
mispredict_tag  out  TAG_W  tag of mispredicted branch, valid with mispredict
tag_error  out  1  one-cycle pulse: resolve with empty queue or tag mismatch
count  out  $clog2(DEPTH)+1  current occupancy
miss_count  out  CNT_W  total mispredicts since reset, saturating

Behaviour:
- Reset (rst_n=0 at posedge): rd_ptr=wr_ptr=0, count=0, miss_count=0. upd_result, upd_taken, mispredict, tag_error = 0. mispredict_tag=0. Queue contents are don't-care. Reset applied mid-operation discards all entries with no pulses.
- Storage: circular buffer of DEPTH entries {taken, tag}. Pointers wrap modulo DEPTH. count is held explicitly, so full and empty are unambiguous.
- pred_ready = (count != DEPTH). It is combinational from registered count only and never depends on res_valid. A full queue rejects enqueue even in a cycle where it pops.
- Enqueue: on pred_valid && pred_ready, write {pred_taken, pred_tag} at wr_ptr, then wr_ptr+1.
- Resolve: on res_valid, the head entry is examined in the same cycle. All outputs are registered and appear exactly 1 cycle after acceptance.
  - Empty (count==0): tag_error=1 next cycle. No pop, no upd_result, no mispredict.
  - head.tag != res_tag: pop the head. tag_error=1, upd_result=0, mispredict=0. The predictor is not trained.
  - Tags match, head.taken == res_taken: pop the head. upd_result=1 and upd_taken=res_taken.
  - Tags match, head.taken != res_taken: upd_result=1, upd_taken=res_taken, mispredict=1, mispredict_tag=res_tag. miss_count increments, holding at all-ones. FLUSH: the queue empties completely (count=0, rd_ptr=wr_ptr). A pred_valid in the same cycle is dropped, since it is younger and on the wrong path.
- Simultaneous enqueue and non-flushing pop: both take effect and count is unchanged. Pushing into an empty queue while res_valid is high is not a hit; it reports the empty tag_error.
- The output pulses are single-cycle. They deassert next cycle unless another resolve is accepted. upd_taken holds its last value between pulses.
- count update: count_next = count + push - pop, or 0 on flush. count never exceeds DEPTH and never goes negative.

Test Plan:
- Reset, then 4 enqueues (taken=1,0,1,1; tags 0x10–0x13) → count=4, pred_ready=0. A 5th pred_valid is ignored and count stays 4.
- Resolve tag 0x10 with res_taken=1 → next cycle upd_result=1, upd_taken=1, mispredict=0, count=3.
- Resolve tag 0x11 with res_taken=1 (predicted 0), with pred_valid in the same cycle → next cycle mispredict=1, mispredict_tag=0x11, upd_result=1, upd_taken=1, count=0, miss_count=1. The same-cycle pred is dropped.
- res_valid with empty queue → tag_error=1, upd_result=0, count=0. Enqueue tag 0x20, then resolve with tag 0x21 → tag_error=1, upd_result=0, count=0.
- Count=2, simultaneous enqueue and correct resolve over 10 cycles → count stays 2. Pointers wrap past DEPTH and entries pop in FIFO order.
- Force 2^CNT_W+3 mispredicts (CNT_W=4 override) → miss_count saturates at 4'hF. rst_n=0 mid-stream then clears count, miss_count and all outputs to 0.
